// File: rtl/glitch_pkg.sv
// Shared types for the glitch sequencer: FSM state encoding, default widths,
// the shadow-register configuration payload and a small field helper.
package glitch_pkg;

   localparam int unsigned GLITCH_CNT_W = 16;
   localparam int unsigned GLITCH_PW_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DELAY,
      GLITCH,
      GAP,
      DONE
   } glitch_seq_state_e;

   typedef struct packed {
      logic [GLITCH_CNT_W-1:0] delay;
      logic [GLITCH_PW_W-1:0]  width;
      logic [GLITCH_PW_W-1:0]  gap;
      logic [GLITCH_PW_W-1:0]  pulses;
   } glitch_cfg_t;

   // Width, gap and pulse-count fields treat 0 as 1.
   function automatic logic [GLITCH_PW_W-1:0] at_least_one(input logic [GLITCH_PW_W-1:0] v);
      return (v == '0) ? GLITCH_PW_W'(1) : v;
   endfunction

endpackage

// File: rtl/glitch_sequencer_if.sv
// Host/trigger side bus of the glitch sequencer: configuration and control in,
// glitch-clock select and status out.
interface glitch_sequencer_if
   import glitch_pkg::*;
#(
   parameter int unsigned CNT_W = GLITCH_CNT_W,
   parameter int unsigned PW_W  = GLITCH_PW_W
);
   logic             arm;
   logic             abort;
   logic             trig;
   logic [CNT_W-1:0] delay;
   logic [PW_W-1:0]  width;
   logic [PW_W-1:0]  gap;
   logic [PW_W-1:0]  pulses;
   logic             sel;
   logic             busy;
   logic             done;
   logic [PW_W-1:0]  pulse_idx;

   modport master (
      output arm, abort, trig, delay, width, gap, pulses,
      input  sel, busy, done, pulse_idx
   );

   modport slave (
      input  arm, abort, trig, delay, width, gap, pulses,
      output sel, busy, done, pulse_idx
   );
endinterface

// File: rtl/glitch_downcnt.sv
// Loadable down-counter with a zero flag; decrements stop at zero so it never wraps.
module glitch_downcnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero_c
);
   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero_c = (count == '0);
endmodule

// File: rtl/glitch_sequencer.sv
// Glitch-clock select sequencer: arm, wait for a trigger edge, delay, then drive
// the select pattern. Multi-pulse bursts are built only with GLITCH_SEQ_BURST_EN.
module glitch_sequencer
   import glitch_pkg::*;
#(
   parameter int unsigned CNT_W = GLITCH_CNT_W,
   parameter int unsigned PW_W  = GLITCH_PW_W
) (
   input logic               clk_in1,
   input logic               rst,
   glitch_sequencer_if.slave bus
);
   localparam int unsigned IDX_W = PW_W + 1;

   glitch_seq_state_e state_q, state_d;
   glitch_cfg_t       cfg_q, cfg_d;
   logic              trig_q, sel_q, busy_q, done_q;
   logic              trig_edge_c, arm_accept_c;
   logic              d_load, d_dec, d_zero;
   logic              w_load, w_dec, w_zero;
   logic              idx_inc;
   logic [PW_W-1:0]   w_init_c;

   assign trig_edge_c  = bus.trig & ~trig_q;
   assign arm_accept_c = (state_q == IDLE) & bus.arm & ~bus.abort;
   assign w_init_c     = PW_W'(at_least_one(cfg_q.width) - GLITCH_PW_W'(1));

   always_comb begin
      cfg_d.delay  = GLITCH_CNT_W'(bus.delay);
      cfg_d.width  = GLITCH_PW_W'(bus.width);
      cfg_d.gap    = GLITCH_PW_W'(bus.gap);
      cfg_d.pulses = GLITCH_PW_W'(bus.pulses);
   end

   glitch_downcnt #(.W(CNT_W)) u_dcnt (
      .clk(clk_in1), .rst_n(rst), .load(d_load),
      .load_val(CNT_W'(cfg_q.delay)), .dec(d_dec), .zero_c(d_zero)
   );

   glitch_downcnt #(.W(PW_W)) u_wcnt (
      .clk(clk_in1), .rst_n(rst), .load(w_load),
      .load_val(w_init_c), .dec(w_dec), .zero_c(w_zero)
   );

`ifdef GLITCH_SEQ_BURST_EN
   logic            g_load, g_dec, g_zero, last_pulse_c;
   logic [PW_W-1:0] pulse_idx_q, n_pulses_c;

   assign n_pulses_c   = PW_W'(at_least_one(cfg_q.pulses));
   assign last_pulse_c = (IDX_W'(pulse_idx_q) + IDX_W'(1)) >= IDX_W'(n_pulses_c);

   glitch_downcnt #(.W(PW_W)) u_gcnt (
      .clk(clk_in1), .rst_n(rst), .load(g_load),
      .load_val(PW_W'(at_least_one(cfg_q.gap) - GLITCH_PW_W'(1))),
      .dec(g_dec), .zero_c(g_zero)
   );

   // Index of the current pulse; saturates at the configured pulse count.
   always_ff @(posedge clk_in1 or negedge rst) begin
      if (!rst) begin
         pulse_idx_q <= '0;
      end else if (arm_accept_c) begin
         pulse_idx_q <= '0;
      end else if (idx_inc && (pulse_idx_q < n_pulses_c)) begin
         pulse_idx_q <= pulse_idx_q + PW_W'(1);
      end
   end

   assign bus.pulse_idx = pulse_idx_q;
`else
   logic unused_burst;
   assign unused_burst  = ^{idx_inc, cfg_q.gap, cfg_q.pulses, IDX_W[0]};
   assign bus.pulse_idx = '0;
`endif

   always_ff @(posedge clk_in1 or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      d_load  = 1'b0;
      d_dec   = 1'b0;
      w_load  = 1'b0;
      w_dec   = 1'b0;
      idx_inc = 1'b0;
`ifdef GLITCH_SEQ_BURST_EN
      g_load  = 1'b0;
      g_dec   = 1'b0;
`endif
      case (state_q)
         IDLE:   if (bus.arm) state_d = ARMED;
         ARMED:  if (trig_edge_c) begin
                    d_load  = 1'b1;
                    state_d = DELAY;
                 end
         DELAY:  if (d_zero) begin
                    w_load  = 1'b1;
                    state_d = GLITCH;
                 end else begin
                    d_dec = 1'b1;
                 end
         GLITCH: if (w_zero) begin
                    idx_inc = 1'b1;
`ifdef GLITCH_SEQ_BURST_EN
                    if (!last_pulse_c) begin
                       g_load  = 1'b1;
                       state_d = GAP;
                    end else begin
                       state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                 end else begin
                    w_dec = 1'b1;
                 end
`ifdef GLITCH_SEQ_BURST_EN
         GAP:    if (g_zero) begin
                    w_load  = 1'b1;
                    state_d = GLITCH;
                 end else begin
                    g_dec = 1'b1;
                 end
`endif
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort wins over arm, trigger and any counter activity.
      if (bus.abort) begin
         state_d = IDLE;
         d_load  = 1'b0;
         d_dec   = 1'b0;
         w_load  = 1'b0;
         w_dec   = 1'b0;
         idx_inc = 1'b0;
`ifdef GLITCH_SEQ_BURST_EN
         g_load  = 1'b0;
         g_dec   = 1'b0;
`endif
      end
   end

   // Outputs are registered from the next state so they align with the state register.
   always_ff @(posedge clk_in1 or negedge rst) begin
      if (!rst) begin
         trig_q <= 1'b0;
         sel_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cfg_q  <= '0;
      end else begin
         trig_q <= bus.trig;
         sel_q  <= (state_d == GLITCH);
         busy_q <= (state_d != IDLE);
         done_q <= (state_d == DONE);
         if (arm_accept_c) cfg_q <= cfg_d;
      end
   end

   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: a cycle-by-cycle expected waveform is
// built from the configuration and compared against sel/busy/done/pulse_idx.
module tb_glitch_sequencer;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned PW_W  = 8;
`ifdef GLITCH_SEQ_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   typedef struct packed {
      logic            sel;
      logic            busy;
      logic            done;
      logic [PW_W-1:0] idx;
   } obs_t;

   logic            clk = 1'b0;
   logic            rst_n;
   int              n_checks = 0;
   int              n_fail   = 0;
   obs_t            exp_q[$];
   logic [PW_W-1:0] idle_idx;
   obs_t            got;

   glitch_sequencer_if #(.CNT_W(CNT_W), .PW_W(PW_W)) bus ();

   glitch_sequencer #(.CNT_W(CNT_W), .PW_W(PW_W)) dut (
      .clk_in1(clk),
      .rst    (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic s, input logic b, input logic d, input logic [PW_W-1:0] i);
      obs_t o;
      o.sel  = s;
      o.busy = b;
      o.done = d;
      o.idx  = i;
      return o;
   endfunction

   function automatic obs_t observe();
      return mk(bus.sel, bus.busy, bus.done, bus.pulse_idx);
   endfunction

   function automatic logic [PW_W-1:0] idx_of(input int n);
      return BURST ? PW_W'(n) : '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_cfg();
      bus.delay  = CNT_W'($urandom);
      bus.width  = PW_W'($urandom);
      bus.gap    = PW_W'($urandom);
      bus.pulses = PW_W'($urandom);
   endtask

   // Expected waveform, one entry per cycle starting with the cycle after the trigger edge.
   task automatic build_exp(input int d, input int w, input int g, input int p);
      int we, ge, pe;
      we = (w == 0) ? 1 : w;
      ge = (g == 0) ? 1 : g;
      pe = BURST ? ((p == 0) ? 1 : p) : 1;
      exp_q.delete();
      for (int i = 0; i <= d; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0));
      for (int k = 0; k < pe; k++) begin
         for (int j = 0; j < we; j++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, idx_of(k)));
         if (k < pe - 1)
            for (int j = 0; j < ge; j++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, idx_of(k + 1)));
      end
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, idx_of(pe)));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, idx_of(pe)));
   endtask

   // Arm with a configuration, idle in ARMED, then give a trigger edge.
   task automatic start_seq(input int d, input int w, input int g, input int p, input int waits);
      bus.delay  = CNT_W'(d);
      bus.width  = PW_W'(w);
      bus.gap    = PW_W'(g);
      bus.pulses = PW_W'(p);
      bus.arm    = 1'b1;
      tick();
      bus.arm = 1'b0;
      scramble_cfg();
      got = observe();
      n_checks++;
      if (got !== mk(1'b0, 1'b1, 1'b0, '0)) begin
         n_fail++;
         $display("FAIL arm_accept: got %h expected %h", got, mk(1'b0, 1'b1, 1'b0, '0));
      end
      for (int i = 0; i < waits; i++) begin
         tick();
         got = observe();
         n_checks++;
         if (got !== mk(1'b0, 1'b1, 1'b0, '0)) begin
            n_fail++;
            $display("FAIL armed_wait: got %h expected %h", got, mk(1'b0, 1'b1, 1'b0, '0));
         end
      end
      bus.trig = 1'b1;
      tick();
      bus.trig = 1'b0;
      build_exp(d, w, g, p);
   endtask

   // Step through expected entries; noise retriggers and re-arms with junk configs.
   task automatic run_expected(input string name, input int last, input bit noise);
      for (int k = 0; k <= last; k++) begin
         if (k > 0) begin
            if (noise) begin
               bus.trig = (k % 2 == 1);
               bus.arm  = (k % 3 == 0);
               scramble_cfg();
            end
            tick();
         end
         got = observe();
         n_checks++;
         if (got !== exp_q[k]) begin
            n_fail++;
            $display("FAIL %s step %0d: got sel=%b busy=%b done=%b idx=%0d, expected sel=%b busy=%b done=%b idx=%0d",
                     name, k, got.sel, got.busy, got.done, got.idx,
                     exp_q[k].sel, exp_q[k].busy, exp_q[k].done, exp_q[k].idx);
         end
      end
      bus.trig = 1'b0;
      bus.arm  = 1'b0;
      if (last == exp_q.size() - 1) idle_idx = exp_q[last].idx;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.arm   = 1'b0;
      bus.abort = 1'b0;
      bus.trig  = 1'b0;
      scramble_cfg();
      repeat (3) @(posedge clk);
      #1;
      got = observe();
      n_checks++;
      if (got !== mk(1'b0, 1'b0, 1'b0, '0)) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected 0", got);
      end
      rst_n = 1'b1;
      tick();
      got = observe();
      n_checks++;
      if (got !== mk(1'b0, 1'b0, 1'b0, '0)) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected 0", got);
      end
      idle_idx = '0;
   endtask

   task automatic test_single();
      start_seq(3, 2, 0, 1, int'($urandom_range(0, 3)));
      run_expected("single", exp_q.size() - 1, 1'b0);
   endtask

   task automatic test_burst();
      start_seq(0, 1, 2, 3, 1);
      run_expected("burst", exp_q.size() - 1, 1'b0);
   endtask

   task automatic test_zero_fields();
      start_seq(0, 0, 0, 0, 0);
      run_expected("zero_fields", exp_q.size() - 1, 1'b1);
   endtask

   task automatic test_ignored();
      obs_t idle;
      idle = mk(1'b0, 1'b0, 1'b0, idle_idx);
      for (int i = 0; i < 4; i++) begin
         bus.trig = (i % 2 == 0);
         tick();
         got = observe();
         n_checks++;
         if (got !== idle) begin
            n_fail++;
            $display("FAIL trig_in_idle: got %h expected %h", got, idle);
         end
      end
      bus.trig  = 1'b0;
      bus.arm   = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.arm   = 1'b0;
      bus.abort = 1'b0;
      got = observe();
      n_checks++;
      if (got !== idle) begin
         n_fail++;
         $display("FAIL arm_with_abort: got %h expected %h", got, idle);
      end
      bus.trig = 1'b1;
      tick();
      bus.trig = 1'b0;
      tick();
      got = observe();
      n_checks++;
      if (got !== idle) begin
         n_fail++;
         $display("FAIL trig_after_arm_abort: got %h expected %h", got, idle);
      end
      start_seq(6, 2, 1, 2, 0);
      run_expected("retrigger_rearm", exp_q.size() - 1, 1'b1);
   endtask

   task automatic test_abort();
      int d;
      d = int'($urandom_range(0, 4));
      start_seq(d, 5, 1, 2, 0);
      run_expected("abort_pre", d + 2, 1'b0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      for (int i = 0; i < 6; i++) begin
         got = observe();
         n_checks++;
         if (got !== mk(1'b0, 1'b0, 1'b0, '0)) begin
            n_fail++;
            $display("FAIL abort_idle cycle %0d: got %h expected 0", i, got);
         end
         tick();
      end
      idle_idx = '0;
      start_seq(2, 1, 1, 1, 0);
      run_expected("after_abort", exp_q.size() - 1, 1'b0);
   endtask

   task automatic test_random();
      int d, w, g, p;
      for (int it = 0; it < 20; it++) begin
         d = int'($urandom_range(0, 12));
         w = int'($urandom_range(0, 5));
         g = int'($urandom_range(0, 4));
         p = int'($urandom_range(0, 4));
         start_seq(d, w, g, p, int'($urandom_range(0, 2)));
         run_expected("random", exp_q.size() - 1, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_async_reset();
      int d;
      d = int'($urandom_range(0, 3));
      start_seq(d, 4, 2, 2, 0);
      run_expected("async_pre", d + 2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      got = observe();
      n_checks++;
      if (got !== mk(1'b0, 1'b0, 1'b0, '0)) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected 0", got);
      end
      tick();
      tick();
      rst_n    = 1'b1;
      idle_idx = '0;
      tick();
      got = observe();
      n_checks++;
      if (got !== mk(1'b0, 1'b0, 1'b0, '0)) begin
         n_fail++;
         $display("FAIL async_release: got %h expected 0", got);
      end
      start_seq(1, 2, 1, 2, 1);
      run_expected("after_reset", exp_q.size() - 1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_zero_fields();
      test_ignored();
      test_abort();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/glitch_sequencer.md
# glitch_sequencer

Controller that decides when the glitch mux switches the design clock from the nominal to the glitch clock. It sits between the host/trigger logic and the clock-select input of the glitch mux, which replaces the free-running counter select. It is armed with a delay, pulse width, gap and pulse count, waits for a trigger edge, then drives a cycle-exact select pattern and reports completion.

## Interface
- CNT_W, 16: width of the trigger-to-first-glitch delay counter.
- PW_W, 8: width of the pulse width, gap and pulse count fields.

- clk_in1  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle request; latches the configuration and arms the sequencer. Honoured only in IDLE.
- abort  in  1  cancels any sequence and returns to IDLE.
- trig  in  1  external trigger, synchronous to clk_in1; the rising edge starts the sequence.
- delay  in  CNT_W  cycles from trigger detection to the first glitch.
- width  in  PW_W  glitch cycles per pulse; 0 is treated as 1.
- gap  in  PW_W  nominal cycles between pulses; 0 is treated as 1.
- pulses  in  PW_W  number of pulses; 0 is treated as 1.
- sel  out  1  registered glitch-clock select to the mux; 1 selects the glitch clock.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.
- pulse_idx  out  PW_W  index of the current or most recent pulse, 0-based.

## Operation
- States: IDLE, ARMED, DELAY, GLITCH, GAP, DONE.
- IDLE: when arm=1 and abort=0, latch delay, width, gap and pulses into shadow registers, clear pulse_idx, and go to ARMED.
- ARMED: a trigger edge is trig=1 while trig_q=0 (trig_q is trig registered). On an edge, load dcnt=delay and go to DELAY.
- DELAY: if dcnt==0, go to GLITCH and load wcnt=max(width,1)-1. Otherwise decrement dcnt.
- GLITCH: sel=1. If wcnt==0, increment pulse_idx:
  - if pulse_idx+1 < max(pulses,1), go to GAP and load gcnt=max(gap,1)-1;
  - otherwise go to DONE.
  - If wcnt≠0, decrement wcnt.
- GAP: sel=0. If gcnt==0, go to GLITCH and reload wcnt. Otherwise decrement gcnt.
- DONE: assert done for exactly one cycle, then go to IDLE.
- abort=1 in any state forces IDLE on the next edge, with sel=0 and no done pulse. abort takes priority over arm and over a trigger in the same cycle.
- arm in any state other than IDLE is ignored. Input changes after arm do not affect a running sequence; only the shadow registers are used.
- Trigger edges outside ARMED are ignored, including retriggers during a sequence. trig_q still updates every cycle.
- Counters never wrap: every decrement is guarded by ==0.
- pulse_idx is PW_W wide and saturates at max(pulses,1).

## Timing
- Reset values: sel=0, busy=0, done=0, pulse_idx=0, state=IDLE, trig_q=0, all counters 0.
- sel is a flop output with no combinational path from any input.
- Latency: if the trigger edge is sampled at edge T, sel rises at edge T+delay+2 (state DELAY at T+1, GLITCH at T+delay+2).
- Each pulse holds sel high for exactly max(width,1) cycles.
- Between pulses, sel is low for exactly max(gap,1) cycles.
- done is high for the one cycle after the last GLITCH cycle; busy drops in the same cycle that done drops.
- Accepting arm makes busy go high on the next cycle.
- A reset assertion mid-sequence clears sel asynchronously.

## Configuration
- GLITCH_SEQ_BURST_EN.
- Defined: multi-pulse bursts operate exactly as described above.
- Not defined: the pulses and gap ports remain but are ignored, the GAP state is not built, the GLITCH exit always goes to DONE, and pulse_idx is tied to 0.

## Structure
- Shared package glitch_pkg holds:
  - the state enum glitch_seq_state_e;
  - default widths GLITCH_CNT_W=16 and GLITCH_PW_W=8;
  - a packed struct glitch_cfg_t {delay, width, gap, pulses} used for the shadow registers.
- One sub-module, glitch_downcnt: a loadable down-counter with a zero flag, instantiated for the delay, width and gap counters.
- The FSM and the edge detector stay in glitch_sequencer.

## Test plan
- Single pulse: delay=3, width=2, pulses=1; trigger edge at cycle 10 → sel high at cycles 15-16, done at 17, busy low from 18.
- Burst (GLITCH_SEQ_BURST_EN defined): delay=0, width=1, gap=2, pulses=3 → sel pattern after the trigger is 1,0,0,1,0,0,1; pulse_idx ends at 3; exactly one done pulse.
- Zero fields: width=0, gap=0, pulses=0 → behaves as 1 pulse of 1 cycle; no counter underflow.
- Abort during GLITCH with width=5, asserted in the 2nd glitch cycle → sel low the next cycle, no done, back in IDLE; a later arm is accepted.
- Ignored events:
  - trigger in IDLE → no sel;
  - arm while busy → shadow values unchanged;
  - retrigger during DELAY → no restart;
  - arm and abort together in IDLE → stays IDLE.
- Asynchronous reset asserted while sel=1 → sel, busy and done are 0 immediately; after release, a normal sequence completes.
